// File: rtl/imem_fetch_pkg.sv
// Core-wide fetch definitions: state encoding, reset PC, instruction width, NOP.
package imem_fetch_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // Decode substitutes this on bubbles; fetch itself never emits it.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    function automatic logic [31:0] align_word(input logic [31:0] byte_addr);
        return byte_addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/imem_fetch_pc.sv
// Program counter register: redirect has priority over the +4 advance; targets are word aligned.
module imem_fetch_pc
    import imem_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    always_comb begin
        // NOTE: default assignment first so no path leaves pc_d unassigned (no latch).
        pc_d = pc_q;
        if (redirect_en) begin
            pc_d = align_word(redirect_pc);
        end else if (advance) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // NOTE: state flops use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, output register with valid/ready, redirect and halt.
// Optional range check on fetch addresses enabled by defining IMEM_FETCH_BOUND_CHECK_EN.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    input  logic               halt_req,
    output logic               halted,
    output logic               fault
);

    logic [1:0]         state_d,    state_q;
    logic               if_valid_d, if_valid_q;
    logic [INSTR_W-1:0] if_instr_d, if_instr_q;
    logic [31:0]        if_pc_d,    if_pc_q;
    logic [31:0]        pc;
    logic               pc_redirect;
    logic               pc_advance;
    logic               load;

`ifdef IMEM_FETCH_BOUND_CHECK_EN
    logic out_of_range;
    assign out_of_range = ({2'b00, pc[31:2]} >= DEPTH_WORDS);
`else
    // Depth only matters when the range check is built in.
    logic unused_depth;
    assign unused_depth = (DEPTH_WORDS == 0);
`endif

    imem_fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect_en (pc_redirect),
        .redirect_pc (redirect_pc),
        .advance     (pc_advance),
        .pc          (pc)
    );

    assign load = (state_q == ST_RUN) && !halt_req && (!if_valid_q || if_ready);

    always_comb begin
        state_d     = state_q;
        if_valid_d  = if_valid_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        pc_redirect = 1'b0;
        pc_advance  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_redirect = 1'b1;
                    if_valid_d  = 1'b0;
                end else if (halt_req) begin
                    if (if_valid_q && if_ready) begin
                        if_valid_d = 1'b0;
                    end
                end else if (load) begin
`ifdef IMEM_FETCH_BOUND_CHECK_EN
                    if (out_of_range) begin
                        state_d    = ST_FAULT;
                        if_valid_d = 1'b0;
                    end else
`endif
                    begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc;
                        if_valid_d = 1'b1;
                        pc_advance = 1'b1;
                    end
                end
                // Halt completes on the edge that leaves the output stage empty.
                if (halt_req && !if_valid_d) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                pc_redirect = redirect_valid;
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
`ifdef IMEM_FETCH_BOUND_CHECK_EN
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
`endif
            default: begin
                state_d    = ST_RUN;
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign imem_addr = {2'b00, pc[31:2]};
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign halted    = (state_q == ST_HALTED);
`ifdef IMEM_FETCH_BOUND_CHECK_EN
    assign fault     = (state_q == ST_FAULT);
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halt_req;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:255];
    assign imem_rdata = mem[imem_addr[7:0]];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the fetch stage
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_valid, m_halted, m_fault;

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .fault          (fault)
    );

    function automatic void model_edge();
        bit transfer;
        if (!rst_n) begin
            m_pc = 32'h0; m_valid = 0; m_instr = 32'h0; m_ipc = 32'h0; m_halted = 0; m_fault = 0;
            return;
        end
        if (m_fault) return;
        if (m_halted) begin
            if (redirect_valid) m_pc = redirect_pc & ~32'h3;
            if (!halt_req) m_halted = 0;
            return;
        end
        transfer = m_valid && if_ready;
        if (redirect_valid) begin
            m_pc = redirect_pc & ~32'h3;
            m_valid = 0;
        end else if (halt_req) begin
            if (transfer) m_valid = 0;
        end else if (!m_valid || if_ready) begin
`ifdef IMEM_FETCH_BOUND_CHECK_EN
            if ((m_pc >> 2) >= 32'd64) begin
                m_fault = 1;
                m_valid = 0;
                return;
            end
`endif
            m_instr = mem[m_pc[9:2]];
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 32'd4;
        end
        if (halt_req && !m_valid) m_halted = 1;
    endfunction

    // Inputs change at the falling edge; the model advances on the rising edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0; if_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80; halt_req = 1'b1; if_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", if_instr); end
        n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", if_pc); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
    endtask

    task automatic test_stream();
        logic [31:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            want = 32'h11 * (i + 1);
            tick();
            n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", i, if_valid); end
            n_cmp++; if (if_instr !== want) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", i, if_instr, want); end
            n_cmp++; if (if_pc !== 32'(i * 4)) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", i, if_pc, i * 4); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick();
        tick();
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (if_instr !== 32'h22 || if_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_instr[%0d]: got %h/%b want 22/1", i, if_instr, if_valid); end
            n_cmp++; if (if_pc !== 32'h4) begin n_err++; $display("FAIL bp_hold_pc[%0d]: got %h want 4", i, if_pc); end
            n_cmp++; if (imem_addr !== 32'h2) begin n_err++; $display("FAIL bp_hold_addr[%0d]: got %h want 2", i, imem_addr); end
        end
        if_ready = 1'b1;
        tick();
        n_cmp++; if (if_instr !== 32'h33 || if_pc !== 32'h8) begin n_err++; $display("FAIL bp_release: got %h@%h want 33@8", if_instr, if_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h23;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %b want 0", if_valid); end
        n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL redir_addr: got %h want 8", imem_addr); end
        tick();
        n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL redir_valid: got %b want 1", if_valid); end
        n_cmp++; if (if_pc !== 32'h20) begin n_err++; $display("FAIL redir_pc: got %h want 20", if_pc); end
        n_cmp++; if (if_instr !== mem[8]) begin n_err++; $display("FAIL redir_instr: got %h want %h", if_instr, mem[8]); end
    endtask

    task automatic test_halt();
        do_reset();
        tick();
        tick();
        tick();
        if_ready = 1'b0; halt_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (if_valid !== 1'b1 || if_instr !== 32'h33) begin n_err++; $display("FAIL halt_hold[%0d]: got %b/%h want 1/33", i, if_valid, if_instr); end
            n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_early[%0d]: got %b want 0", i, halted); end
        end
        if_ready = 1'b1;
        tick();
        n_cmp++; if (if_valid !== 1'b0 || halted !== 1'b1) begin n_err++; $display("FAIL halt_enter: got valid %b halted %b want 0/1", if_valid, halted); end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (halted !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL halt_redir: got halted %b addr %h want 1/10", halted, imem_addr); end
        halt_req = 1'b0;
        tick();
        n_cmp++; if (halted !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL halt_exit: got halted %b valid %b want 0/0", halted, if_valid); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin n_err++; $display("FAIL halt_resume: got %b@%h want 1@40", if_valid, if_pc); end
        n_cmp++; if (if_instr !== mem[16]) begin n_err++; $display("FAIL halt_resume_instr: got %h want %h", if_instr, mem[16]); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL midrst: got valid %b addr %h want 0/0", if_valid, imem_addr); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h11) begin n_err++; $display("FAIL midrst_restart: got %b %h@%h want 1 11@0", if_valid, if_instr, if_pc); end
    endtask

`ifdef IMEM_FETCH_BOUND_CHECK_EN
    task automatic test_fault();
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_early: got %b want 0", fault); end
        tick();
        n_cmp++; if (fault !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL fault_set: got fault %b valid %b want 1/0", fault, if_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h0; halt_req = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b0; halt_req = 1'b0;
        n_cmp++; if (fault !== 1'b1 || halted !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL fault_sticky: got fault %b halted %b valid %b want 1/0/0", fault, halted, if_valid); end
        do_reset();
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_clear: got %b want 0", fault); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst_n          = ($urandom_range(0, 63) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                         : 32'($urandom_range(0, 32'h3FF));
            if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
            if_ready       = ($urandom_range(0, 3) != 0);
            tick();
            n_cmp++; if (if_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", c, if_valid, m_valid); end
            if (m_valid) begin
                n_cmp++; if (if_instr !== m_instr || if_pc !== m_ipc) begin n_err++; $display("FAIL rnd_out@%0d: got %h@%h want %h@%h", c, if_instr, if_pc, m_instr, m_ipc); end
            end
            n_cmp++; if (imem_addr !== {2'b00, m_pc[31:2]}) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", c, imem_addr, {2'b00, m_pc[31:2]}); end
            n_cmp++; if (halted !== m_halted || fault !== m_fault) begin n_err++; $display("FAIL rnd_status@%0d: got h%b f%b want h%b f%b", c, halted, fault, m_halted, m_fault); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0; if_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_reset_midstream();
`ifdef IMEM_FETCH_BOUND_CHECK_EN
        test_fault();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
